// File: rtl/occ_pkg.sv
// Shared types and helpers for the multi-gate occupancy counter.
package occ_pkg;

    // Per-gate direction-detection states: entry path (a first) and exit path (b first)
    typedef enum logic [2:0] {
        UNBLOCKED = 3'd0,
        ENT_A     = 3'd1,
        ENT_AB    = 3'd2,
        ENT_B     = 3'd3,
        EXT_B     = 3'd4,
        EXT_AB    = 3'd5,
        EXT_A     = 3'd6
    } t_gate_state;

    // Width needed to hold an occupancy in the range 0..capacity
    function automatic int occ_cnt_w(input int capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/occ_gate_fsm.sv
// One gate's direction detector: outer sensor a, inner sensor b.
// A car entering blocks a, then a+b, then b, then clears; exit is the mirror.
// Event pulses are Mealy outputs, suppressed while reset is asserted.
module occ_gate_fsm
    import occ_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    output logic o_car_enter,
    output logic o_car_exit,
    output logic o_seq_err
);

    t_gate_state r_state;
    t_gate_state w_next;
    logic        w_enter;
    logic        w_exit;
    logic        w_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= UNBLOCKED;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and event decode from current state and the {a,b} sensor pair
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            UNBLOCKED: begin
                case ({i_a, i_b})
                    2'b10:   w_next = ENT_A;
                    2'b01:   w_next = EXT_B;
                    2'b11:   w_err  = 1'b1;
                    default: w_next = UNBLOCKED;
                endcase
            end
            ENT_A: begin
                case ({i_a, i_b})
                    2'b11:   w_next = ENT_AB;
                    2'b00:   w_next = UNBLOCKED;
                    2'b01:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = ENT_A;
                endcase
            end
            ENT_AB: begin
                case ({i_a, i_b})
                    2'b01:   w_next = ENT_B;
                    2'b10:   w_next = ENT_A;
                    2'b00:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = ENT_AB;
                endcase
            end
            ENT_B: begin
                case ({i_a, i_b})
                    2'b00:   begin w_next = UNBLOCKED; w_enter = 1'b1; end
                    2'b11:   w_next = ENT_AB;
                    2'b10:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = ENT_B;
                endcase
            end
            EXT_B: begin
                case ({i_a, i_b})
                    2'b11:   w_next = EXT_AB;
                    2'b00:   w_next = UNBLOCKED;
                    2'b10:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = EXT_B;
                endcase
            end
            EXT_AB: begin
                case ({i_a, i_b})
                    2'b10:   w_next = EXT_A;
                    2'b01:   w_next = EXT_B;
                    2'b00:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = EXT_AB;
                endcase
            end
            EXT_A: begin
                case ({i_a, i_b})
                    2'b00:   begin w_next = UNBLOCKED; w_exit = 1'b1; end
                    2'b11:   w_next = EXT_AB;
                    2'b01:   begin w_next = UNBLOCKED; w_err = 1'b1; end
                    default: w_next = EXT_A;
                endcase
            end
            default: w_next = UNBLOCKED;
        endcase
    end

    assign o_car_enter = w_enter & ~i_rst;
    assign o_car_exit  = w_exit  & ~i_rst;
    assign o_seq_err   = w_err   & ~i_rst;

endmodule

// File: rtl/multi_gate_occupancy_counter.sv
// Lot occupancy tracker: NUM_GATES direction-detecting gates feeding one
// saturating occupancy counter with full/empty and sticky over/underflow.
// Build option OCC_SENSOR_SYNC_EN inserts a 2-flop synchronizer on every
// sensor bit ahead of the gate FSMs (adds 2 cycles of event latency).
module multi_gate_occupancy_counter
    import occ_pkg::*;
#(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 200,
    parameter int CNT_W     = occ_cnt_w(CAPACITY)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_GATES-1:0] i_a,
    input  logic [NUM_GATES-1:0] i_b,
    input  logic                 i_clr,
    output logic [NUM_GATES-1:0] o_car_enter,
    output logic [NUM_GATES-1:0] o_car_exit,
    output logic [NUM_GATES-1:0] o_seq_err,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    // Delta width holds -NUM_GATES..+NUM_GATES; sum width covers count plus delta with margin
    localparam int DW = $clog2(NUM_GATES + 1) + 1;
    localparam int SW = CNT_W + DW + 1;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [NUM_GATES-1:0] w_a;
    logic [NUM_GATES-1:0] w_b;

`ifdef OCC_SENSOR_SYNC_EN
    logic [NUM_GATES-1:0] r_a_s1;
    logic [NUM_GATES-1:0] r_a_s2;
    logic [NUM_GATES-1:0] r_b_s1;
    logic [NUM_GATES-1:0] r_b_s2;

    // Two-stage synchronizer on each asynchronous sensor bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_s1 <= '0;
            r_a_s2 <= '0;
            r_b_s1 <= '0;
            r_b_s2 <= '0;
        end else begin
            r_a_s1 <= i_a;
            r_a_s2 <= r_a_s1;
            r_b_s1 <= i_b;
            r_b_s2 <= r_b_s1;
        end
    end

    assign w_a = r_a_s2;
    assign w_b = r_b_s2;
`else
    assign w_a = i_a;
    assign w_b = i_b;
`endif

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        occ_gate_fsm u_gate (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_a         (w_a[g]),
            .i_b         (w_b[g]),
            .o_car_enter (o_car_enter[g]),
            .o_car_exit  (o_car_exit[g]),
            .o_seq_err   (o_seq_err[g])
        );
    end

    logic [DW-2:0]          w_pop_enter;
    logic [DW-2:0]          w_pop_exit;
    logic signed [DW-1:0]   w_delta;
    logic signed [SW-1:0]   w_sum;
    logic                   w_over;
    logic                   w_under;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic                   r_underflow;

    // Count this cycle's enter and exit pulses across all gates
    always_comb begin
        w_pop_enter = '0;
        w_pop_exit  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            w_pop_enter = w_pop_enter + (DW-1)'(o_car_enter[g]);
            w_pop_exit  = w_pop_exit  + (DW-1)'(o_car_exit[g]);
        end
    end

    // Net change and unclamped next occupancy; enters and exits cancel before clamping
    assign w_delta = $signed({1'b0, w_pop_enter}) - $signed({1'b0, w_pop_exit});
    assign w_sum   = $signed({{(SW-CNT_W){1'b0}}, r_count}) + SW'(w_delta);
    assign w_over  = (w_sum > CAP_S);
    assign w_under = (w_sum < 0);

    // Occupancy register with clamp and sticky saturation flags; clear drops same-cycle events
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_over) begin
            r_count    <= CNT_W'(CAPACITY);
            r_overflow <= 1'b1;
        end else if (w_under) begin
            r_count     <= '0;
            r_underflow <= 1'b1;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign o_count     = r_count;
    assign o_full      = (r_count == CNT_W'(CAPACITY));
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule
